// File: rtl/aes_pnm_job_scheduler.sv
// Round-robin scheduler that shares one AES PNM engine among N_REQ requesters, with a watchdog on done.
// Latency: grant 1 cycle after req is sampled in IDLE, eng_start 1 cycle later, ack 1 cycle after eng_done.
// Backpressure: requests are level-held until ack. `define AES_PNM_SCHED_PRIO_EN makes port 0 strict-high priority.
module aes_pnm_job_scheduler #(
    parameter int N_REQ   = 4,
    parameter int TMO_W   = 16,
    parameter int TMO_CYC = 4000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] req_enc_dec,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] ack,
    output logic             err,
    output logic             eng_start,
    output logic             eng_enc_dec,
    input  logic             eng_done,
    output logic             busy
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);
    localparam logic [TMO_W:0]   TMO_END  = (TMO_W + 1)'(TMO_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] own_idx;
    logic [TMO_W-1:0] timer;
    logic [TMO_W:0]   timer_nxt;
    logic             tmo_hit;
    logic [PTR_W:0]   pick;
    logic             pick_vld;
    logic [PTR_W-1:0] pick_idx;

    // Scans from ptr upward with wrap; the lowest offset from ptr is assigned last and wins.
    function automatic logic [PTR_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [PTR_W-1:0] ptr);
        logic [PTR_W:0]   res;
        logic [PTR_W-1:0] idx;
        res = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = PTR_W'((int'(ptr) + i) % N_REQ);
`ifdef AES_PNM_SCHED_PRIO_EN
            if (r[idx] && (idx != '0)) res = {1'b1, idx};
`else
            if (r[idx]) res = {1'b1, idx};
`endif
        end
`ifdef AES_PNM_SCHED_PRIO_EN
        if (r[0]) res = {1'b1, PTR_W'(0)};
`endif
        return res;
    endfunction

    always_comb begin
        pick      = rr_pick(req, rr_ptr);
        pick_vld  = pick[PTR_W];
        pick_idx  = pick[PTR_W-1:0];
        timer_nxt = {1'b0, timer} + (TMO_W + 1)'(1);
        tmo_hit   = (timer_nxt >= TMO_END);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            own_idx     <= '0;
            timer       <= '0;
            gnt         <= '0;
            ack         <= '0;
            err         <= 1'b0;
            eng_start   <= 1'b0;
            eng_enc_dec <= 1'b0;
            busy        <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            ack       <= '0;
            err       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        gnt         <= ONE_HOT0 << pick_idx;
                        own_idx     <= pick_idx;
                        eng_enc_dec <= req_enc_dec[pick_idx];
                        busy        <= 1'b1;
                        state       <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    eng_start <= 1'b1;
                    state     <= S_ISSUE;
                end
                S_ISSUE: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // done is checked first so a coincident timeout reports success
                    if (eng_done) begin
                        ack   <= gnt;
                        state <= S_RESP;
                    end else begin
                        timer <= timer_nxt[TMO_W-1:0];
                        if (tmo_hit) begin
                            ack   <= gnt;
                            err   <= 1'b1;
                            state <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
`ifdef AES_PNM_SCHED_PRIO_EN
                    // port 0 sits outside the rotation and leaves the pointer alone
                    if (own_idx != '0)
                        rr_ptr <= (own_idx == LAST_IDX) ? PTR_W'(1) : own_idx + PTR_W'(1);
`else
                    rr_ptr <= (own_idx == LAST_IDX) ? '0 : own_idx + PTR_W'(1);
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_pnm_job_scheduler.sv
// Bench for aes_pnm_job_scheduler: fixed vector table, hand corner sequences, then random jobs vs a priority model.
module tb_aes_pnm_job_scheduler;
    localparam int N   = 4;
    localparam int TW  = 16;
    localparam int TMO = 50;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req, req_enc_dec, gnt, ack;
    logic         err, eng_start, eng_enc_dec, eng_done, busy;

    always #5 clk = ~clk;

    aes_pnm_job_scheduler #(.N_REQ(N), .TMO_W(TW), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_enc_dec(req_enc_dec),
        .gnt(gnt), .ack(ack), .err(err), .eng_start(eng_start),
        .eng_enc_dec(eng_enc_dec), .eng_done(eng_done), .busy(busy)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int m_ptr  = 0;

    typedef struct {
        logic [N-1:0] r;
        logic [N-1:0] ed;
        int           dly;
        logic [N-1:0] eg;
        logic         ee;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner = requesting port at the smallest ring distance from the pointer.
    function automatic int model_pick(input logic [N-1:0] r);
        int best, bestd, d, p;
        best = -1;
        bestd = N + 1;
`ifdef AES_PNM_SCHED_PRIO_EN
        if (r[0]) return 0;
        p = (m_ptr == 0) ? 1 : m_ptr;
        for (int i = 1; i < N; i++)
            if (r[i]) begin
                d = (i - p + (N - 1)) % (N - 1);
                if (d < bestd) begin bestd = d; best = i; end
            end
`else
        p = m_ptr;
        for (int i = 0; i < N; i++)
            if (r[i]) begin
                d = (i - p + N) % N;
                if (d < bestd) begin bestd = d; best = i; end
            end
`endif
        return best;
    endfunction

    task automatic model_retire(input int w);
`ifdef AES_PNM_SCHED_PRIO_EN
        if (w != 0) m_ptr = (w % (N - 1)) + 1;
`else
        m_ptr = (w + 1) % N;
`endif
    endtask

    // Runs one job from an IDLE cycle; dly = WAIT cycle index where done is raised, -1 = never.
    task automatic do_job(input logic [N-1:0] r, input logic [N-1:0] ed, input int dly,
                          input logic [N-1:0] eg, input logic ee, input logic noise, input logic drop);
        int  w, waitn;
        logic bad;
        w = 0;
        for (int i = 0; i < N; i++) if (eg[i]) w = i;
        waitn = (dly >= 0 && dly <= TMO - 2) ? dly + 1 : TMO - 1;
        req = r; req_enc_dec = ed; eng_done = noise;
        @(posedge clk); #1;
        chk("grant_gnt", gnt, eg);
        chk("grant_busy", busy, 1);
        chk("grant_nostart", eng_start, 0);
        chk("grant_encdec", eng_enc_dec, ed[w]);
        if (drop) req = '0;
        req_enc_dec = ~ed;
        @(posedge clk); #1;
        chk("issue_start", eng_start, 1);
        chk("issue_gnt", gnt, eg);
        bad = 1'b0;
        for (int c = 0; c < waitn; c++) begin
            @(posedge clk); #1;
            bad |= eng_start | (ack != '0) | (gnt != eg) | !busy | (eng_enc_dec != ed[w]);
            eng_done = (c == dly);
        end
        chk("wait_quiet", bad, 0);
        @(posedge clk); #1;
        eng_done = 1'b0;
        chk("resp_ack", ack, eg);
        chk("resp_err", err, ee);
        chk("resp_gnt", gnt, eg);
        chk("resp_nostart", eng_start, 0);
        model_retire(w);
        @(posedge clk); #1;
        chk("idle_out", {gnt, ack, err, busy}, 0);
    endtask

    initial begin
        logic [N-1:0] r, ed, eg;
        int           dly, sel, w;

        rst_n = 1'b0; req = '0; req_enc_dec = '0; eng_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_start", eng_start, 0);
        chk("rst_encdec", eng_enc_dec, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef AES_PNM_SCHED_PRIO_EN
        tbl[0]  = '{4'b0100, 4'b0100, 29, 4'b0100, 1'b0};
        tbl[1]  = '{4'b1111, 4'b1010,  3, 4'b0001, 1'b0};
        tbl[2]  = '{4'b1111, 4'b1010,  0, 4'b0001, 1'b0};
        tbl[3]  = '{4'b1111, 4'b0101,  1, 4'b0001, 1'b0};
        tbl[4]  = '{4'b1110, 4'b0101,  2, 4'b1000, 1'b0};
        tbl[5]  = '{4'b1110, 4'b0010, -1, 4'b0010, 1'b1};
        tbl[6]  = '{4'b1110, 4'b0010, 48, 4'b0100, 1'b0};
        tbl[7]  = '{4'b0011, 4'b1000,  5, 4'b0001, 1'b0};
        tbl[8]  = '{4'b0110, 4'b0110,  2, 4'b0010, 1'b0};
        tbl[9]  = '{4'b1111, 4'b1111,  4, 4'b0001, 1'b0};
        tbl[10] = '{4'b1010, 4'b0000, 47, 4'b1000, 1'b0};
        tbl[11] = '{4'b0011, 4'b0001, 49, 4'b0001, 1'b1};
`else
        tbl[0]  = '{4'b0100, 4'b0100, 29, 4'b0100, 1'b0};
        tbl[1]  = '{4'b1111, 4'b1010,  3, 4'b1000, 1'b0};
        tbl[2]  = '{4'b1111, 4'b1010,  0, 4'b0001, 1'b0};
        tbl[3]  = '{4'b1111, 4'b0101,  1, 4'b0010, 1'b0};
        tbl[4]  = '{4'b1111, 4'b0101,  2, 4'b0100, 1'b0};
        tbl[5]  = '{4'b0011, 4'b0010, -1, 4'b0001, 1'b1};
        tbl[6]  = '{4'b0011, 4'b0010, 48, 4'b0010, 1'b0};
        tbl[7]  = '{4'b1001, 4'b1000,  5, 4'b1000, 1'b0};
        tbl[8]  = '{4'b0110, 4'b0110,  2, 4'b0010, 1'b0};
        tbl[9]  = '{4'b1111, 4'b1111,  4, 4'b0100, 1'b0};
        tbl[10] = '{4'b1111, 4'b0000, 47, 4'b1000, 1'b0};
        tbl[11] = '{4'b0001, 4'b0001, 49, 4'b0001, 1'b1};
`endif
        for (int i = 0; i < 12; i++)
            do_job(tbl[i].r, tbl[i].ed, tbl[i].dly, tbl[i].eg, tbl[i].ee, (i % 3) == 1, (i % 4) == 2);

        // done pulses with nothing in flight must not produce an ack
        req = '0; eng_done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_done_ignored", {gnt, ack, err, busy, eng_start}, 0);
        eng_done = 1'b0;

        // reset in the middle of WAIT drops the job with no ack
        req = 4'b0100; req_enc_dec = 4'b0100;
        repeat (6) @(posedge clk);
        #1;
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_out", {gnt, ack, err, eng_start, eng_enc_dec, busy}, 0);
        req = 4'b1010; req_enc_dec = 4'b0000;
        @(posedge clk); #1;
        chk("rst_hold_out", {gnt, ack, err, eng_start, eng_enc_dec, busy}, 0);
        rst_n = 1'b1; m_ptr = 0;
        do_job(4'b1010, 4'b0010, 6, 4'b0010, 1'b0, 1'b0, 1'b0);

        // all requesters held: strict rotation from the current pointer (2 after granting port 1)
        for (int k = 0; k < 8; k++) begin
`ifdef AES_PNM_SCHED_PRIO_EN
            eg = 4'b0001;
`else
            eg = 4'b0001 << ((2 + k) % N);
`endif
            do_job(4'b1111, k[3:0], k % 3, eg, 1'b0, k[0], 1'b0);
        end

        for (int k = 0; k < 40; k++) begin
            r   = 4'($urandom_range(1, 15));
            ed  = 4'($urandom);
            sel = $urandom_range(0, 9);
            dly = (sel < 6) ? $urandom_range(0, 12) : (sel == 6) ? 47 : (sel == 7) ? 48 : (sel == 8) ? 49 : -1;
            w   = model_pick(r);
            eg  = 4'b0001 << w;
            do_job(r, ed, dly, eg, !(dly >= 0 && dly <= TMO - 2),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
